prng_rr_scheduler: RTL and testbench

//  Shares one 256-bit PCG random source between NUM_REQ requesters.

---
 rtl/prng_rr_scheduler_pkg.sv | 21 ++
 rtl/prng_rr_scheduler_if.sv | 16 +
 rtl/prng_rr_scheduler_arb.sv | 40 ++++
 rtl/prng_rr_scheduler.sv | 126 ++++++++++++
 tb/tb_prng_rr_scheduler.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prng_rr_scheduler_pkg.sv
// prng_sched_pkg: shared definitions for the PCG round-robin scheduler.
//   sched_state_t : scheduler FSM states (RESEED, WARMUP, SERVE), 2-bit
//   WORD_W        : default random word / seed width (256)
//   CNT_W         : width of the delivered-word counter (16)
//   rr_wrap()     : advance a round-robin index by one, wrapping at n
package prng_sched_pkg;

    typedef enum logic [1:0] {
        RESEED = 2'd0,
        WARMUP = 2'd1,
        SERVE  = 2'd2
    } sched_state_t;

    localparam int WORD_W = 256;
    localparam int CNT_W  = 16;

    function automatic int rr_wrap(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/prng_rr_scheduler_if.sv
// prng_rr_scheduler_if: consumer-side request/acknowledge bus.
//   req   : level request per requester, held until its own ack
//   ack   : one-hot single-cycle acknowledge, rdata valid with it
//   rdata : delivered random word
// Modports: master = consumer side, slave = scheduler side.
interface prng_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 256
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic [WORD_W-1:0]  rdata;

    modport master (output req, input ack, input rdata);
    modport slave  (input req, output ack, output rdata);
endinterface

// File: rtl/prng_rr_scheduler_arb.sv
// prng_rr_arb: combinational round-robin arbiter.
//   req       : request vector
//   mask      : requesters excluded this cycle
//   pointer   : index given first priority
//   grant     : one-hot winner (all zero when nobody is eligible)
//   grant_idx : index of the winner
module prng_rr_arb #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [NUM_REQ-1:0] eligible;
    logic               found;

    assign eligible = req & ~mask;

    // Scan starting at the pointer and wrapping; first eligible wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = int'(pointer) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && eligible[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/prng_rr_scheduler.sv
// prng_rr_scheduler: shares one PCG random source between NUM_REQ requesters.
// Each grant delivers exactly one generator word; the generator is reseeded
// (gen_rst pulse, seed load, warm-up discard) after reset and every RESEED_CNT words.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   bus (slave)  : req in, one-hot ack out, rdata out
//   seed_in      : entropy word, sampled on entry to RESEED
//   gen_rst      : generator reset (high throughout RESEED)
//   gen_seed     : registered seed to the generator
//   gen_data     : generator output, new value every clock
//   ready        : high only while serving
//   word_cnt     : words delivered since the last reseed (saturating)
//   force_reseed : only with PRNG_SCHED_FORCE_RESEED_EN defined; forces a reseed from SERVE
module prng_rr_scheduler #(
    parameter  int NUM_REQ    = 4,
    parameter  int WORD_W     = prng_sched_pkg::WORD_W,
    parameter  int RESEED_CNT = 1024,
    parameter  int RST_CYC    = 2,
    parameter  int WARMUP_CYC = 4,
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W      = prng_sched_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    prng_rr_scheduler_if.slave   bus,
    input  logic [WORD_W-1:0]    seed_in,
    output logic                 gen_rst,
    output logic [WORD_W-1:0]    gen_seed,
    input  logic [WORD_W-1:0]    gen_data,
`ifdef PRNG_SCHED_FORCE_RESEED_EN
    input  logic                 force_reseed,
`endif
    output logic                 ready,
    output logic [CNT_W-1:0]     word_cnt
);
    import prng_sched_pkg::*;

    sched_state_t       state, state_next;
    logic [15:0]        phase_cnt;
    logic [31:0]        served_cnt;
    logic [IDX_W-1:0]   pointer;
    logic [NUM_REQ-1:0] ack_q;
    logic [WORD_W-1:0]  rdata_q;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               pick_en;
    logic               last_word;
    logic               force_req;

`ifdef PRNG_SCHED_FORCE_RESEED_EN
    assign force_req = force_reseed;
`else
    assign force_req = 1'b0;
`endif

    // The acking requester is masked so a held req yields exactly one ack per grant.
    prng_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (bus.req),
        .mask      (ack_q),
        .pointer   (pointer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign last_word = (served_cnt + 32'd1) >= 32'(RESEED_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RESEED;
        else      state <= state_next;
    end

    // A grant picked in the same cycle as a reseed trigger still issues its ack;
    // the state change only stops further picks.
    always_comb begin
        state_next = state;
        pick_en    = 1'b0;
        gen_rst    = 1'b0;
        ready      = 1'b0;
        case (state)
            RESEED: begin
                gen_rst = 1'b1;
                if (phase_cnt == 16'(RST_CYC - 1)) state_next = WARMUP;
            end
            WARMUP: begin
                if (phase_cnt == 16'(WARMUP_CYC - 1)) state_next = SERVE;
            end
            SERVE: begin
                ready   = 1'b1;
                pick_en = |grant;
                if ((pick_en && last_word) || force_req) state_next = RESEED;
            end
            default: state_next = RESEED;
        endcase
    end

    // Datapath: phase timing, seed latch, grant delivery and word counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_cnt  <= '0;
            served_cnt <= '0;
            pointer    <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            gen_seed   <= '0;
        end else begin
            if (state != state_next || state == SERVE) phase_cnt <= '0;
            else                                       phase_cnt <= phase_cnt + 16'd1;

            if (state == RESEED && phase_cnt == 16'd0) gen_seed <= seed_in;

            ack_q <= pick_en ? grant : '0;
            if (pick_en) begin
                rdata_q    <= gen_data;
                pointer    <= IDX_W'(rr_wrap(int'(grant_idx), NUM_REQ));
                served_cnt <= served_cnt + 32'd1;
            end

            if (state == WARMUP && state_next == SERVE) served_cnt <= '0;
        end
    end

    assign word_cnt  = (served_cnt > 32'h0000_FFFF) ? 16'hFFFF : served_cnt[15:0];
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_prng_rr_scheduler.sv
// tb_prng_rr_scheduler: directed self-checking bench for prng_rr_scheduler
// built with NUM_REQ=4, RESEED_CNT=8, RST_CYC=2, WARMUP_CYC=4.
// The generator is modelled as a counter-derived word that changes on every
// falling edge, so each delivered word is predictable and unique.
// Optional feature macro: PRNG_SCHED_FORCE_RESEED_EN.
module tb_prng_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 256;
    localparam logic [WORD_W-1:0] SEED_A = {8{32'h1234_5678}};
    localparam logic [WORD_W-1:0] SEED_B = {8{32'hCAFE_F00D}};
    localparam logic [WORD_W-1:0] SEED_C = {8{32'h0BAD_BEEF}};

    logic              clk;
    logic              rst;
    logic [WORD_W-1:0] seed_in;
    logic              gen_rst;
    logic [WORD_W-1:0] gen_seed;
    logic [WORD_W-1:0] gen_data;
    logic              ready;
    logic [15:0]       word_cnt;
    logic              force_reseed;
    int                gen_cnt;
    int                tests_run;
    int                failed;

    prng_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) bus ();

    prng_rr_scheduler #(
        .NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .RESEED_CNT(8), .RST_CYC(2), .WARMUP_CYC(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .seed_in      (seed_in),
        .gen_rst      (gen_rst),
        .gen_seed     (gen_seed),
        .gen_data     (gen_data),
`ifdef PRNG_SCHED_FORCE_RESEED_EN
        .force_reseed (force_reseed),
`endif
        .ready        (ready),
        .word_cnt     (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WORD_W-1:0] mk(input int n);
        logic [31:0] w;
        w = 32'(n) ^ 32'h5A5A_0000;
        return {8{w}};
    endfunction

    // Generator model: fresh word every falling edge.
    initial begin
        gen_cnt  = 0;
        gen_data = mk(0);
        forever begin
            @(negedge clk);
            gen_cnt  = gen_cnt + 1;
            gen_data = mk(gen_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset and run the full reseed sequence; ends one step into SERVE.
    task automatic reset_to_serve(input logic [WORD_W-1:0] seed);
        bus.req      = '0;
        force_reseed = 1'b0;
        seed_in      = seed;
        rst          = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.req = '0; seed_in = SEED_A; force_reseed = 1'b0;
        #3;
        tests_run++; if (bus.ack !== 4'b0000) begin failed++; $display("[TB] FAIL reset_ack: got %b want 0000", bus.ack); end
        tests_run++; if (gen_rst !== 1'b1) begin failed++; $display("[TB] FAIL reset_gen_rst: got %b want 1", gen_rst); end
        tests_run++; if (ready !== 1'b0) begin failed++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
        tests_run++; if (word_cnt !== 16'd0) begin failed++; $display("[TB] FAIL reset_word_cnt: got %0d want 0", word_cnt); end
        tests_run++; if (bus.rdata !== '0) begin failed++; $display("[TB] FAIL reset_rdata: got %h want 0", bus.rdata); end
        tests_run++; if (gen_seed !== '0) begin failed++; $display("[TB] FAIL reset_gen_seed: got %h want 0", gen_seed); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++; if (gen_rst !== 1'b1) begin failed++; $display("[TB] FAIL rel_gen_rst_c1: got %b want 1", gen_rst); end
        tick();
        tests_run++; if (gen_rst !== 1'b1) begin failed++; $display("[TB] FAIL rel_gen_rst_c2: got %b want 1", gen_rst); end
        tests_run++; if (gen_seed !== SEED_A) begin failed++; $display("[TB] FAIL rel_gen_seed: got %h want %h", gen_seed, SEED_A); end
        tick();
        tests_run++; if (gen_rst !== 1'b0) begin failed++; $display("[TB] FAIL warmup_gen_rst: got %b want 0", gen_rst); end
        tests_run++; if (ready !== 1'b0) begin failed++; $display("[TB] FAIL warmup_ready_w0: got %b want 0", ready); end
        repeat (3) tick();
        tests_run++; if (ready !== 1'b0) begin failed++; $display("[TB] FAIL warmup_ready_w3: got %b want 0", ready); end
        tick();
        tests_run++; if (ready !== 1'b1) begin failed++; $display("[TB] FAIL serve_ready: got %b want 1", ready); end
    endtask

    task automatic test_single();
        logic [WORD_W-1:0] exp_rd;
        reset_to_serve(SEED_A);
        bus.req = 4'b0001;
        tick();
        exp_rd = mk(gen_cnt);
        tests_run++; if (bus.ack !== 4'b0001) begin failed++; $display("[TB] FAIL single_ack: got %b want 0001", bus.ack); end
        tests_run++; if (bus.rdata !== exp_rd) begin failed++; $display("[TB] FAIL single_rdata: got %h want %h", bus.rdata, exp_rd); end
        tests_run++; if (word_cnt !== 16'd1) begin failed++; $display("[TB] FAIL single_word_cnt: got %0d want 1", word_cnt); end
        bus.req = 4'b0000;
        tick();
        tests_run++; if (bus.ack !== 4'b0000) begin failed++; $display("[TB] FAIL single_ack_drop: got %b want 0000", bus.ack); end
        tests_run++; if (bus.rdata !== exp_rd) begin failed++; $display("[TB] FAIL single_rdata_hold: got %h want %h", bus.rdata, exp_rd); end
        tests_run++; if (word_cnt !== 16'd1) begin failed++; $display("[TB] FAIL single_word_cnt_hold: got %0d want 1", word_cnt); end
    endtask

    task automatic test_fairness();
        logic [NUM_REQ-1:0] exp_ack;
        logic [WORD_W-1:0]  prev_rd;
        logic [WORD_W-1:0]  exp_rd;
        reset_to_serve(SEED_A);
        bus.req = 4'b1111;
        prev_rd = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_ack = 4'b0001 << (k % 4);
            exp_rd  = mk(gen_cnt);
            tests_run++; if (bus.ack !== exp_ack) begin failed++; $display("[TB] FAIL fair_ack_%0d: got %b want %b", k, bus.ack, exp_ack); end
            tests_run++; if (bus.rdata !== exp_rd) begin failed++; $display("[TB] FAIL fair_rdata_%0d: got %h want %h", k, bus.rdata, exp_rd); end
            if (k > 0) begin
                tests_run++; if (bus.rdata === prev_rd) begin failed++; $display("[TB] FAIL fair_repeat_%0d: got %h want a new word", k, bus.rdata); end
            end
            prev_rd = bus.rdata;
        end
        bus.req = 4'b0000;
        tick();
        tests_run++; if (word_cnt !== 16'd5) begin failed++; $display("[TB] FAIL fair_word_cnt: got %0d want 5", word_cnt); end
    endtask

    task automatic test_reseed_boundary();
        logic [NUM_REQ-1:0] exp_ack;
        reset_to_serve(SEED_A);
        bus.req = 4'b0011;
        seed_in = SEED_B;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_ack = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            tests_run++; if (bus.ack !== exp_ack) begin failed++; $display("[TB] FAIL bound_ack_%0d: got %b want %b", k, bus.ack, exp_ack); end
            tests_run++; if (word_cnt !== 16'(k + 1)) begin failed++; $display("[TB] FAIL bound_cnt_%0d: got %0d want %0d", k, word_cnt, k + 1); end
            tests_run++; if (ready !== (k < 7)) begin failed++; $display("[TB] FAIL bound_ready_%0d: got %b want %b", k, ready, (k < 7)); end
        end
        tests_run++; if (gen_rst !== 1'b1) begin failed++; $display("[TB] FAIL bound_gen_rst: got %b want 1", gen_rst); end
        bus.req = 4'b0000;
        tick();
        tests_run++; if (bus.ack !== 4'b0000) begin failed++; $display("[TB] FAIL bound_no_9th: got %b want 0000", bus.ack); end
        tests_run++; if (gen_seed !== SEED_B) begin failed++; $display("[TB] FAIL bound_seed: got %h want %h", gen_seed, SEED_B); end
        tests_run++; if (gen_rst !== 1'b1) begin failed++; $display("[TB] FAIL bound_gen_rst_c2: got %b want 1", gen_rst); end
        tick();
        tests_run++; if (gen_rst !== 1'b0) begin failed++; $display("[TB] FAIL bound_warmup: got %b want 0", gen_rst); end
        bus.req = 4'b0100;
        repeat (3) tick();
        tests_run++; if (bus.ack !== 4'b0000) begin failed++; $display("[TB] FAIL pend_no_ack_warmup: got %b want 0000", bus.ack); end
        tick();
        tests_run++; if (ready !== 1'b1) begin failed++; $display("[TB] FAIL bound_reentry_ready: got %b want 1", ready); end
        tests_run++; if (word_cnt !== 16'd0) begin failed++; $display("[TB] FAIL bound_reentry_cnt: got %0d want 0", word_cnt); end
        tick();
        tests_run++; if (bus.ack !== 4'b0100) begin failed++; $display("[TB] FAIL pend_ack: got %b want 0100", bus.ack); end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        reset_to_serve(SEED_A);
        bus.req = 4'b0001;
        tick();
        tests_run++; if (bus.ack !== 4'b0001) begin failed++; $display("[TB] FAIL arst_pre_ack: got %b want 0001", bus.ack); end
        #2;
        rst     = 1'b0;
        bus.req = 4'b0000;
        seed_in = SEED_C;
        #1;
        tests_run++; if (bus.ack !== 4'b0000) begin failed++; $display("[TB] FAIL arst_ack: got %b want 0000", bus.ack); end
        tests_run++; if (bus.rdata !== '0) begin failed++; $display("[TB] FAIL arst_rdata: got %h want 0", bus.rdata); end
        tests_run++; if (gen_rst !== 1'b1) begin failed++; $display("[TB] FAIL arst_gen_rst: got %b want 1", gen_rst); end
        tests_run++; if (ready !== 1'b0) begin failed++; $display("[TB] FAIL arst_ready: got %b want 0", ready); end
        tests_run++; if (word_cnt !== 16'd0) begin failed++; $display("[TB] FAIL arst_word_cnt: got %0d want 0", word_cnt); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        tests_run++; if (gen_rst !== 1'b1) begin failed++; $display("[TB] FAIL arst_replay_rst: got %b want 1", gen_rst); end
        tests_run++; if (gen_seed !== SEED_C) begin failed++; $display("[TB] FAIL arst_replay_seed: got %h want %h", gen_seed, SEED_C); end
        tick();
        tests_run++; if (gen_rst !== 1'b0) begin failed++; $display("[TB] FAIL arst_replay_warm: got %b want 0", gen_rst); end
        repeat (3) tick();
        tests_run++; if (ready !== 1'b0) begin failed++; $display("[TB] FAIL arst_replay_early: got %b want 0", ready); end
        tick();
        tests_run++; if (ready !== 1'b1) begin failed++; $display("[TB] FAIL arst_replay_ready: got %b want 1", ready); end
    endtask

`ifdef PRNG_SCHED_FORCE_RESEED_EN
    task automatic test_force_reseed();
        reset_to_serve(SEED_A);
        bus.req = 4'b0011;
        repeat (3) tick();
        tests_run++; if (word_cnt !== 16'd3) begin failed++; $display("[TB] FAIL force_pre_cnt: got %0d want 3", word_cnt); end
        force_reseed = 1'b1;
        tick();
        tests_run++; if (bus.ack !== 4'b0010) begin failed++; $display("[TB] FAIL force_pending_ack: got %b want 0010", bus.ack); end
        tests_run++; if (word_cnt !== 16'd4) begin failed++; $display("[TB] FAIL force_cnt: got %0d want 4", word_cnt); end
        tests_run++; if (gen_rst !== 1'b1) begin failed++; $display("[TB] FAIL force_gen_rst: got %b want 1", gen_rst); end
        tests_run++; if (ready !== 1'b0) begin failed++; $display("[TB] FAIL force_ready: got %b want 0", ready); end
        force_reseed = 1'b0;
        bus.req      = 4'b0000;
        tick();
        tests_run++; if (bus.ack !== 4'b0000) begin failed++; $display("[TB] FAIL force_no_more: got %b want 0000", bus.ack); end
    endtask
`endif

    initial begin
        tests_run    = 0;
        failed       = 0;
        rst          = 1'b0;
        bus.req      = '0;
        seed_in      = SEED_A;
        force_reseed = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_reseed_boundary();
        test_async_reset();
`ifdef PRNG_SCHED_FORCE_RESEED_EN
        test_force_reseed();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
